fibonacci_request_sequencer: RTL and testbench

Upstream/downstream wrapper stage for the Fibonacci calculator. It accepts index requests over a valid/ready port and drives the calculator's start/index inputs one request at a time. It captures each result on the calculator's done pulse and queues `{index, value, timeout}` entries in a small FIFO for a valid/ready consumer. A watchdog ensures that a calculator which never signals done cannot hang the pipeline.

---
 rtl/fibonacci_request_sequencer.sv | 124 ++++++++++++
 tb/tb_fibonacci_request_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fibonacci_request_sequencer.sv
// Request sequencer for the Fibonacci calculator: issues one request at a time, guards it
// with a watchdog, and queues {index, value, timeout} results in a small FIFO.
module fibonacci_request_sequencer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic [4:0]  req_index,
    output logic        req_ready,
    output logic        fib_start,
    output logic [4:0]  fib_n,
    input  logic        fib_done,
    input  logic [27:0] fib_value,
    output logic        res_valid,
    output logic [4:0]  res_index,
    output logic [27:0] res_value,
    output logic        res_timeout,
    input  logic        res_ready,
    output logic        busy
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(TIMEOUT);
    localparam logic [PtrW:0]   FullCount   = (PtrW + 1)'(DEPTH);
    localparam logic [CntW-1:0] ExpireCount = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_t;

    state_t          state;
    logic [CntW-1:0] wd_cnt;

    logic [33:0]     mem [DEPTH];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [PtrW:0]   count;

    logic            accept;
    logic            push;
    logic            pop;
    logic [33:0]     push_entry;
    logic [33:0]     head;

    // Space is reserved at acceptance, so a completing request always finds room.
    assign req_ready  = (state == StIdle) && (count < FullCount);
    assign accept     = req_valid && req_ready;
    assign push       = (state == StWait) && (fib_done || (wd_cnt == ExpireCount));
    assign push_entry = fib_done ? {fib_n, fib_value, 1'b0} : {fib_n, 28'h0, 1'b1};
    assign pop        = res_valid && res_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= StIdle;
            wd_cnt    <= '0;
            fib_n     <= '0;
            fib_start <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (accept) begin
                        fib_n     <= req_index;
                        fib_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= StIssue;
                    end
                end
                StIssue: begin
                    fib_start <= 1'b0;
                    wd_cnt    <= '0;
                    state     <= StWait;
                end
                StWait: begin
                    if (push) begin
                        busy  <= 1'b0;
                        state <= StIdle;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: begin
                    fib_start <= 1'b0;
                    busy      <= 1'b0;
                    state     <= StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Head fields read as zero while empty so stale storage never leaks out.
    assign head        = mem[rd_ptr];
    assign res_valid   = (count != '0);
    assign res_index   = res_valid ? head[33:29] : 5'd0;
    assign res_value   = res_valid ? head[28:1] : 28'd0;
    assign res_timeout = res_valid ? head[0] : 1'b0;

endmodule

// File: tb/tb_fibonacci_request_sequencer.sv
// Bench for fibonacci_request_sequencer: table of single requests, directed corner cases,
// then randomized traffic against a queue-based model of the result stream.
module tb_fibonacci_request_sequencer;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic [4:0]  req_index;
    logic        req_ready;
    logic        fib_start;
    logic [4:0]  fib_n;
    logic        fib_done;
    logic [27:0] fib_value;
    logic        res_valid;
    logic [4:0]  res_index;
    logic [27:0] res_value;
    logic        res_timeout;
    logic        res_ready;
    logic        busy;

    always #5 clk = ~clk;

    fibonacci_request_sequencer #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_index   (req_index),
        .req_ready   (req_ready),
        .fib_start   (fib_start),
        .fib_n       (fib_n),
        .fib_done    (fib_done),
        .fib_value   (fib_value),
        .res_valid   (res_valid),
        .res_index   (res_index),
        .res_value   (res_value),
        .res_timeout (res_timeout),
        .res_ready   (res_ready),
        .busy        (busy)
    );

    typedef struct {
        logic [4:0]  idx;
        logic [27:0] val;
        logic        to;
    } entry_t;

    typedef struct {
        logic [4:0]  idx;
        int          delay;   // cycles from fib_start to fib_done; 0 = never
        logic [27:0] val;
        logic        to;
        int          vis;     // cycle the entry becomes visible, handshake = cycle 0
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          pend = 0;
    int          resp_delay = 1;
    logic [4:0]  resp_n = '0;
    int          starts = 0;
    bit          sb_on = 1'b0;
    entry_t      exp_q[$];
    logic [4:0]  issue_q[$];

    function automatic logic [27:0] fib(input int n);
        longint a = 0;
        longint b = 1;
        longint t;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return 28'(a);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_head(input string name, input logic [4:0] idx, input logic [27:0] val,
                              input logic to);
        check({name, " valid"}, res_valid, 1);
        check({name, " index"}, res_index, idx);
        check({name, " value"}, res_value, val);
        check({name, " timeout"}, res_timeout, to);
    endtask

    // Observe the cycle about to end, step one clock, then play the calculator's part.
    task automatic cycle();
        entry_t e;
        int     d;
        if (sb_on && reset_n) begin
            if (req_valid && req_ready) begin
                d = ($urandom_range(0, 99) < 4) ? 0 : int'($urandom_range(1, 12));
                resp_delay = d;
                issue_q.push_back(req_index);
                e.idx = req_index;
                e.to  = (d == 0) || (d > int'(TIMEOUT));
                e.val = e.to ? 28'h0 : fib(int'(req_index));
                exp_q.push_back(e);
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check("rand spurious entry", res_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rand index", res_index, e.idx);
                    check("rand value", res_value, e.val);
                    check("rand timeout", res_timeout, e.to);
                end
            end
            check("rand req_ready while busy", req_ready & busy, 0);
        end
        @(posedge clk);
        #1;
        cyc++;
        fib_done  = 1'b0;
        fib_value = 28'($urandom);
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                fib_done  = 1'b1;
                fib_value = fib(int'(resp_n));
            end
        end
        if (fib_start) begin
            starts++;
            resp_n = fib_n;
            pend   = resp_delay;
            if (sb_on) begin
                if (issue_q.size() == 0) check("rand unexpected start", fib_start, 0);
                else check("rand fib_n", fib_n, issue_q.pop_front());
            end
        end
    endtask

    task automatic send(input logic [4:0] idx, input int bound, output bit ok);
        ok        = 1'b0;
        req_valid = 1'b1;
        req_index = idx;
        for (int i = 0; i < bound; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                cycle();
                break;
            end
            cycle();
        end
        req_valid = 1'b0;
    endtask

    task automatic pop_one(input string name, input logic [4:0] idx, input logic [27:0] val,
                           input logic to);
        check_head(name, idx, val, to);
        res_ready = 1'b1;
        cycle();
        res_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global time limit: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        vec_t      vecs[9];
        bit        ok;
        bit        low_all;
        int        n;
        logic [4:0]  b2b_idx[4];
        logic [27:0] b2b_val[4];

        vecs[0] = '{idx: 5'd10, delay: 8,  val: 28'd55,      to: 1'b0, vis: 10};
        vecs[1] = '{idx: 5'd0,  delay: 1,  val: 28'd0,       to: 1'b0, vis: 3};
        vecs[2] = '{idx: 5'd1,  delay: 1,  val: 28'd1,       to: 1'b0, vis: 3};
        vecs[3] = '{idx: 5'd2,  delay: 3,  val: 28'd1,       to: 1'b0, vis: 5};
        vecs[4] = '{idx: 5'd20, delay: 5,  val: 28'd6765,    to: 1'b0, vis: 7};
        vecs[5] = '{idx: 5'd31, delay: 2,  val: 28'd1346269, to: 1'b0, vis: 4};
        vecs[6] = '{idx: 5'd5,  delay: 64, val: 28'd5,       to: 1'b0, vis: 66};
        vecs[7] = '{idx: 5'd7,  delay: 0,  val: 28'd0,       to: 1'b1, vis: 66};
        vecs[8] = '{idx: 5'd9,  delay: 65, val: 28'd0,       to: 1'b1, vis: 66};

        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_index = '0;
        fib_done  = 1'b0;
        fib_value = '0;
        res_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset res_valid", res_valid, 0);
        check("reset res_index", res_index, 0);
        check("reset res_value", res_value, 0);
        check("reset res_timeout", res_timeout, 0);
        check("reset busy", busy, 0);
        check("reset fib_start", fib_start, 0);
        check("reset fib_n", fib_n, 0);
        reset_n = 1'b1;
        check("reset req_ready", req_ready, 1);

        // Single requests, including watchdog expiry and done exactly at expiry.
        for (int i = 0; i < 9; i++) begin
            check("vec ready idle", req_ready, 1);
            resp_delay = vecs[i].delay;
            starts     = 0;
            req_valid  = 1'b1;
            req_index  = vecs[i].idx;
            cycle();
            req_valid  = 1'b0;
            req_index  = 5'($urandom);
            check("vec start", fib_start, 1);
            check("vec fib_n", fib_n, vecs[i].idx);
            check("vec busy", busy, 1);
            check("vec ready while busy", req_ready, 0);
            n = 1;
            while (!res_valid && n < 200) begin
                cycle();
                n++;
            end
            check("vec latency", n, vecs[i].vis);
            check("vec busy done", busy, 0);
            check("vec ready done", req_ready, 1);
            check("vec start count", starts, 1);
            pop_one("vec head", vecs[i].idx, vecs[i].val, vecs[i].to);
            repeat (3) cycle();
            check("vec no extra push", res_valid, 0);
        end

        // Back-to-back with no pop: FIFO fills, req_ready holds off until one pop.
        resp_delay = 2;
        b2b_idx = '{5'd4, 5'd5, 5'd6, 5'd7};
        b2b_val = '{28'd3, 28'd5, 28'd8, 28'd13};
        for (int i = 3; i <= 6; i++) begin
            send(5'(i), 20, ok);
            check("b2b accept", ok, 1);
        end
        repeat (6) cycle();
        req_valid = 1'b1;
        req_index = 5'd7;
        low_all   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (req_ready) low_all = 1'b0;
            cycle();
        end
        req_valid = 1'b0;
        check("b2b ready low when full", low_all, 1);
        pop_one("b2b first", 5'd3, 28'd2, 1'b0);
        check("b2b ready after pop", req_ready, 1);
        send(5'd7, 5, ok);
        check("b2b accept after pop", ok, 1);
        repeat (6) cycle();
        for (int i = 0; i < 4; i++) pop_one("b2b order", b2b_idx[i], b2b_val[i], 1'b0);
        check("b2b drained", res_valid, 0);

        // Push and pop in the same cycle with the FIFO at its reserved limit.
        for (int i = 11; i <= 13; i++) begin
            send(5'(i), 20, ok);
            check("pp accept", ok, 1);
        end
        repeat (5) cycle();
        resp_delay = 4;
        send(5'd14, 20, ok);
        check("pp accept last", ok, 1);
        n = 0;
        while (!fib_done && n < 20) begin
            cycle();
            n++;
        end
        check("pp done seen", fib_done, 1);
        pop_one("pp pop at done", 5'd11, 28'd89, 1'b0);
        pop_one("pp order", 5'd12, 28'd144, 1'b0);
        pop_one("pp order", 5'd13, 28'd233, 1'b0);
        pop_one("pp order", 5'd14, 28'd377, 1'b0);
        check("pp drained", res_valid, 0);

        // Reset while a request waits and two entries sit in the FIFO.
        resp_delay = 2;
        send(5'd15, 20, ok);
        send(5'd16, 20, ok);
        repeat (5) cycle();
        check("rst two entries", res_valid, 1);
        resp_delay = 10;
        send(5'd17, 20, ok);
        repeat (3) cycle();
        #2;
        reset_n = 1'b0;
        #1;
        check("rst async res_valid", res_valid, 0);
        check("rst async res_index", res_index, 0);
        check("rst async res_value", res_value, 0);
        check("rst async busy", busy, 0);
        check("rst async fib_n", fib_n, 0);
        cycle();
        reset_n = 1'b1;
        check("rst release res_valid", res_valid, 0);
        check("rst release req_ready", req_ready, 1);
        starts = 0;
        repeat (12) cycle();
        check("rst stray done ignored", res_valid, 0);
        check("rst stray busy", busy, 0);
        check("rst stray no start", starts, 0);

        // Randomized traffic checked against the result-stream model.
        sb_on = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_index = 5'($urandom);
            res_ready = ($urandom_range(0, 9) < 6);
            cycle();
        end
        req_valid = 1'b0;
        res_ready = 1'b1;
        n = 0;
        while ((exp_q.size() > 0 || busy) && n < 400) begin
            cycle();
            n++;
        end
        check("rand drain queue", exp_q.size(), 0);
        check("rand drain valid", res_valid, 0);
        sb_on = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
